// File: rtl/sdc_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_emu_pkg
//  Description : Shared types and constants for the SD card sector emulator.
//  Revision    : 1.0  initial release
// ============================================================================
package sdc_emu_pkg;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int OFFSET_W     = 9;
    localparam int IMG_ADDR_W   = 41;

endpackage
`default_nettype wire

// File: rtl/sdc_sector_emu.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_sector_emu
//  Description : Sector reader stand-in. Accepts a per-drive read request,
//                waits a card-like start latency, fetches 512 bytes from an
//                image backend over req/ack and streams them as addressed
//                byte strobes followed by a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sdc_sector_emu
    import sdc_emu_pkg::*;
#(
    parameter int START_DELAY = 16,
    parameter int BYTE_GAP    = 2,
    parameter int DRIVES      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DRIVES-1:0]     sdc_rd,
    input  logic [31:0]           sdc_sector,
    output logic                  sdc_busy,
    output logic                  sdc_done,
    output logic                  sdc_byte_in_strobe,
    output logic [OFFSET_W-1:0]   sdc_byte_in_addr,
    output logic [7:0]            sdc_byte_in_data,
    output logic                  img_req,
    output logic [1:0]            img_drive,
    output logic [IMG_ADDR_W-1:0] img_addr,
    input  logic                  img_ack,
    input  logic [7:0]            img_data
);

    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(SECTOR_BYTES - 1);
    localparam logic [15:0]         DELAY_LOAD  = 16'(START_DELAY);
    // gap_cnt counts cycles since the last strobe; the next strobe may land
    // once this many cycles have elapsed before its own cycle.
    localparam logic [7:0]          GAP_MIN     = 8'(BYTE_GAP - 1);

    state_t                state, state_nxt;
    logic [DRIVES-1:0]     rd_prev;
    logic [DRIVES-1:0]     rd_rise;
    logic [31:0]           sector_r;
    logic [1:0]            drive_r;
    logic [OFFSET_W-1:0]   offset;
    logic [15:0]           dly_cnt;
    logic [7:0]            gap_cnt;
    logic [7:0]            cap_data;
    logic                  gap_ok;

    // Lowest-numbered requesting drive wins; the rest are dropped.
    function automatic logic [1:0] lowest_bit(input logic [DRIVES-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = DRIVES - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign rd_rise = sdc_rd & ~rd_prev;
    assign gap_ok  = (gap_cnt >= GAP_MIN);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; the fetch overlaps the inter-byte gap so spacing is
    // max(BYTE_GAP, fetch latency + 1)
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (rd_rise != '0) state_nxt = ST_DELAY;
            ST_DELAY:  if (dly_cnt == 16'd1) state_nxt = ST_FETCH;
            ST_FETCH:  if (img_ack) state_nxt = gap_ok ? ST_STROBE : ST_GAP;
            ST_STROBE: state_nxt = (offset == LAST_OFFSET) ? ST_DONE : ST_FETCH;
            ST_GAP:    if (gap_ok) state_nxt = ST_STROBE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request latching, counters, byte capture and presented byte registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_prev          <= '0;
            sector_r         <= '0;
            drive_r          <= '0;
            offset           <= '0;
            dly_cnt          <= '0;
            gap_cnt          <= '0;
            cap_data         <= '0;
            sdc_byte_in_addr <= '0;
            sdc_byte_in_data <= '0;
        end else begin
            rd_prev <= sdc_rd;

            if (state == ST_STROBE)    gap_cnt <= 8'd1;
            else if (gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (rd_rise != '0) begin
                        drive_r  <= lowest_bit(rd_rise);
                        sector_r <= sdc_sector;
                        offset   <= '0;
                        dly_cnt  <= DELAY_LOAD;
                        gap_cnt  <= 8'hFF;
                    end
                end
                ST_DELAY:  dly_cnt <= dly_cnt - 16'd1;
                ST_FETCH:  if (img_ack) cap_data <= img_data;
                ST_STROBE: if (offset != LAST_OFFSET) offset <= offset + 1'b1;
                default:   ;
            endcase

            if (state_nxt == ST_STROBE) begin
                sdc_byte_in_addr <= offset;
                sdc_byte_in_data <= (state == ST_FETCH) ? img_data : cap_data;
            end
        end
    end

    assign sdc_busy           = (state == ST_DELAY) || (state == ST_FETCH) ||
                                (state == ST_STROBE) || (state == ST_GAP);
    assign sdc_done           = (state == ST_DONE);
    assign sdc_byte_in_strobe = (state == ST_STROBE);
    assign img_req            = (state == ST_FETCH);
    assign img_drive          = drive_r;
    assign img_addr           = {sector_r, offset};

endmodule
`default_nettype wire

// File: tb/tb_sdc_sector_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdc_sector_emu
//  Description : Scoreboard bench for sdc_sector_emu with a latency-
//                programmable image backend model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdc_sector_emu;

    localparam int START_DELAY = 16;
    localparam int BYTE_GAP    = 2;
    localparam int DRIVES      = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  sdc_rd = '0;
    logic [31:0] sdc_sector = '0;
    logic        sdc_busy, sdc_done, sdc_byte_in_strobe;
    logic [8:0]  sdc_byte_in_addr;
    logic [7:0]  sdc_byte_in_data;
    logic        img_req;
    logic [1:0]  img_drive;
    logic [40:0] img_addr;
    logic        img_ack;
    logic [7:0]  img_data;

    logic        stray_ack = 1'b0;
    int          lat = 1;
    int          req_cnt = 0;
    int          cyc = 0;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t        q[$];
    exp_t        e;

    int          n_cmp = 0;
    int          n_err = 0;

    // expectations set by the stimulus process
    int          xfer_id = 0;
    int          exp_gap = 2;
    logic [31:0] exp_sector = '0;
    logic [1:0]  exp_drive = '0;

    // observations owned by the monitor
    int          seen_id = 0;
    int          done_cnt = 0;
    int          xfer_strobes = 0;
    int          last_strobe = 0;
    bit          have_last = 1'b0;
    int          busy_rise_cyc = -1;
    int          first_req_cyc = -1;
    logic [40:0] last_req_addr = '0;

    sdc_sector_emu #(
        .START_DELAY (START_DELAY),
        .BYTE_GAP    (BYTE_GAP),
        .DRIVES      (DRIVES)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .sdc_rd             (sdc_rd),
        .sdc_sector         (sdc_sector),
        .sdc_busy           (sdc_busy),
        .sdc_done           (sdc_done),
        .sdc_byte_in_strobe (sdc_byte_in_strobe),
        .sdc_byte_in_addr   (sdc_byte_in_addr),
        .sdc_byte_in_data   (sdc_byte_in_data),
        .img_req            (img_req),
        .img_drive          (img_drive),
        .img_addr           (img_addr),
        .img_ack            (img_ack),
        .img_data           (img_data)
    );

    function automatic logic [7:0] bfn(input logic [40:0] a);
        return a[7:0] ^ a[16:9] ^ a[40:33];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always #5 clk = ~clk;

    // Backend: ack arrives on the lat-th cycle that req is held
    assign img_ack  = (img_req && (req_cnt == lat - 1)) || stray_ack;
    assign img_data = img_ack ? bfn(img_addr) : 8'hA5;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (img_req && !img_ack) req_cnt <= req_cnt + 1;
        else                     req_cnt <= 0;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (seen_id != xfer_id) begin
            seen_id       = xfer_id;
            have_last     = 1'b0;
            xfer_strobes  = 0;
            busy_rise_cyc = -1;
            first_req_cyc = -1;
        end
        if (rstn) begin
            if (sdc_busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
            if (img_req) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                last_req_addr = img_addr;
                if (q.size() == 0) begin
                    check_eq("req_unexpected", 64'(img_req), 64'd0);
                end else begin
                    check_eq("img_addr", 64'(img_addr), 64'({exp_sector, q[0].addr}));
                    check_eq("img_drive", 64'(img_drive), 64'(exp_drive));
                end
            end
            if (sdc_byte_in_strobe) begin
                if (q.size() == 0) begin
                    check_eq("strobe_unexpected", 64'(sdc_byte_in_strobe), 64'd0);
                end else begin
                    e = q.pop_front();
                    check_eq("byte_addr", 64'(sdc_byte_in_addr), 64'(e.addr));
                    check_eq("byte_data", 64'(sdc_byte_in_data), 64'(e.data));
                end
                if (have_last) check_eq("strobe_spacing", 64'(cyc - last_strobe), 64'(exp_gap));
                last_strobe  = cyc;
                have_last    = 1'b1;
                xfer_strobes = xfer_strobes + 1;
            end
            if (sdc_done) begin
                done_cnt = done_cnt + 1;
                check_eq("done_busy_low", 64'(sdc_busy), 64'd0);
                check_eq("done_all_bytes", 64'(q.size()), 64'd0);
            end
        end
    end

    task automatic start_xfer(input logic [3:0] bits, input logic [31:0] sec,
                              input logic [1:0] drv, input int latency, output int edge_cyc);
        lat        = latency;
        exp_gap    = (latency + 1 > BYTE_GAP) ? latency + 1 : BYTE_GAP;
        exp_sector = sec;
        exp_drive  = drv;
        q.delete();
        for (int off = 0; off < 512; off++) begin
            q.push_back({9'(off), bfn({sec, 9'(off)})});
        end
        xfer_id    = xfer_id + 1;
        sdc_sector = sec;
        sdc_rd     = bits;
        edge_cyc   = cyc;
    endtask

    task automatic wait_done(input int bound);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < bound) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("xfer_done_once", 64'(done_cnt - start), 64'd1);
    endtask

    task automatic idle_quiet(input int cycles, input string tag);
        int start;
        start = done_cnt;
        repeat (cycles) @(negedge clk);
        check_eq(tag, 64'({sdc_busy, 32'(done_cnt - start)}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec;
        int wcnt;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 64'({sdc_busy, sdc_done, sdc_byte_in_strobe, sdc_byte_in_addr,
                      sdc_byte_in_data, img_req, img_drive}), 64'd0);
        check_eq("reset_img_addr", 64'(img_addr), 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Stray ack in IDLE must be ignored
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        idle_quiet(5, "stray_ack_ignored");

        // Single read, drive 0, sector 5, fast backend
        start_xfer(4'b0001, 32'd5, 2'd0, 1, ec);
        @(negedge clk);
        sdc_rd = 4'b0000;
        wait_done(3000);
        check_eq("busy_latency", 64'(busy_rise_cyc - ec), 64'd1);
        check_eq("first_req_delay", 64'(first_req_cyc - busy_rise_cyc), 64'(START_DELAY));
        check_eq("held_addr", 64'({sdc_byte_in_addr, sdc_byte_in_data}),
                 64'({9'd511, bfn({32'd5, 9'd511})}));
        idle_quiet(10, "single_quiet");

        // Priority: 1010 selects drive 1, drive 3 never served
        start_xfer(4'b1010, 32'h0000_0123, 2'd1, 1, ec);
        wait_done(3000);
        idle_quiet(40, "priority_no_second");
        sdc_rd = 4'b0000;
        @(negedge clk);

        // Retrigger ignored while busy
        start_xfer(4'b0001, 32'h00AB_CDEF, 2'd0, 1, ec);
        wcnt = 0;
        while (xfer_strobes < 200 && wcnt < 2000) begin
            @(negedge clk);
            wcnt++;
        end
        sdc_rd = 4'b0101;
        @(negedge clk);
        sdc_rd = 4'b0001;
        wait_done(3000);
        idle_quiet(40, "retrigger_ignored");
        sdc_rd = 4'b0000;
        @(negedge clk);

        // Slow backend, 7-cycle fetch
        start_xfer(4'b0100, 32'h1234_5678, 2'd2, 7, ec);
        @(negedge clk);
        sdc_rd = 4'b0000;
        wait_done(6000);
        check_eq("slow_last_addr", 64'(last_req_addr), 64'({32'h1234_5678, 9'd511}));

        // Reset mid-transfer
        start_xfer(4'b0001, 32'd9, 2'd0, 1, ec);
        @(negedge clk);
        sdc_rd = 4'b0000;
        wcnt = 0;
        while (xfer_strobes < 100 && wcnt < 2000) begin
            @(negedge clk);
            wcnt++;
        end
        check_eq("reached_byte_100", 64'(xfer_strobes >= 100), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        q.delete();
        check_eq("midreset_outputs",
                 64'({sdc_busy, sdc_done, sdc_byte_in_strobe, img_req, sdc_byte_in_addr}), 64'd0);
        idle_quiet(20, "midreset_no_done");
        start_xfer(4'b0001, 32'd9, 2'd0, 1, ec);
        @(negedge clk);
        sdc_rd = 4'b0000;
        wait_done(3000);

        // Maximum sector number
        start_xfer(4'b1000, 32'hFFFF_FFFF, 2'd3, 1, ec);
        @(negedge clk);
        sdc_rd = 4'b0000;
        wait_done(3000);
        check_eq("max_last_addr", 64'(last_req_addr), 64'h1FF_FFFF_FFFF);
        check_eq("total_done", 64'(done_cnt), 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
